aes_encrypt_controller: RTL and testbench
=========================================

// Module: aes_encrypt_controller
// PURPOSE
//  Iterative AES-128 encryption sequencer. Accepts one plaintext/key pair over
//  a valid/ready handshake and applies the initial AddRoundKey. It then runs
//  NR rounds through an external combinational round datapath, one per clock
//  (full round for 1..NR-1, final round at NR), and presents the ciphertext on
//  a valid/ready output. The key is expanded on the fly; SubWord goes through
//  an external S-box port.
// PARAMETERS
//  NR         10     number of rounds; AES-128 requires 10; legal range 2..14
//  RCON_INIT  8'h01  Rcon value used to derive the round-1 key
// PORTS
//  clk         in   1    single clock, all state updates on rising edge
//  rst         in   1    asynchronous, active-high reset
//  in_valid    in   1    plaintext/key request valid
//  in_ready    out  1    controller idle; request accepted when in_valid & in_ready
//  plaintext   in   128  AES byte 0 in [127:120]
//  key         in   128  cipher key; w0=[127:96] .. w3=[31:0]
//  out_valid   out  1    ciphertext valid; held until out_ready
//  out_ready   in   1    consumer accepts ciphertext
//  ciphertext  out  128  result, same byte order as plaintext
//  rnd_state   out  128  state fed to round datapath (= state_reg)
//  rnd_key     out  128  round key for current round (combinational expansion)
//  rnd_final   out  1    1: datapath runs final round (no MixColumns)
//  rnd_result  in   128  combinational datapath output for rnd_state/rnd_key
//  ks_word     out  32   RotWord(w3 of key_reg) = {key_reg[23:0],key_reg[31:24]}
//  ks_sub      in   32   SubWord(ks_word), combinational from external S-box
//  round_idx   out  4    0 in IDLE, 1..NR in ROUND, NR in DONE
// BEHAVIOUR
//  Regs: state_reg[127:0], key_reg[127:0], rcon[7:0], round[3:0], fsm.
//  Reset (async): fsm=IDLE, state_reg=0, key_reg=0, rcon=RCON_INIT, round=0.
//  Output values during and after reset: in_ready=1, out_valid=0,
//  ciphertext=0, rnd_final=0, round_idx=0.
//  Key expansion (combinational from key_reg, rcon, ks_sub):
//   n0=w0^ks_sub^{rcon,24'h0}; n1=w1^n0; n2=w2^n1; n3=w3^n2;
//   rnd_key={n0,n1,n2,n3}.
//  xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
//  FSM:
//   IDLE : in_ready=1. On in_valid: state_reg<=plaintext^key; key_reg<=key;
//          rcon<=RCON_INIT; round<=1; -> ROUND.
//   ROUND: in_ready=0, rnd_final=(round==NR). Each edge: state_reg<=rnd_result;
//          key_reg<=rnd_key; rcon<=xtime(rcon).
//          If round==NR -> DONE; else round<=round+1.
//   DONE : out_valid=1, ciphertext=state_reg (registered, stable).
//          On out_ready -> IDLE; round<=0.
//  Latency: accept on edge T -> out_valid high after edge T+NR (NR ROUND cycles).
//  No output back-pressure stall inside ROUND; stalls only in DONE.
//  Throughput: at most one block per NR+2 cycles. A new request is accepted
//  no earlier than the cycle after DONE exits, never in the same cycle.
//  in_valid while busy: ignored. plaintext/key sampled only on the accept
//  edge and may change afterwards.
//  out_ready while out_valid=0: ignored.
//  rst mid-operation: abort immediately to the reset values; no out_valid pulse.
//  Outside ROUND: rnd_* and ks_word are don't-care but deterministic (from regs).
// TESTING
//  FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c,
//   pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32,
//   out_valid exactly 10 cycles after accept; round-10 rnd_key d014f9a8c9ee2589e13f0cc8b6630ca6.
//  FIPS-197 App.C.1: key 000102030405060708090a0b0c0d0e0f,
//   pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//  Back-pressure: hold out_ready=0 for 20 cycles -> ct stable, out_valid=1,
//   in_ready=0; then pulse out_ready -> IDLE next edge.
//  Busy rejection: drive in_valid with App.C.1 data during round 5 of App.B run
//   -> ignored, App.B ct unchanged.
//  Reset in round 4 -> out_valid=0 and round_idx=0 immediately; then App.C.1
//   runs correctly.
//  Back-to-back: 8 random blocks, in_valid and out_ready always 1 -> all match
//   the golden model, each NR+2 cycles apart; rnd_final high only at round NR.

Source files
------------

// File: rtl/aes_encrypt_controller.sv
// Iterative AES-128 encryption sequencer: one round per clock through an external
// round datapath, on-the-fly key expansion through an external S-box port.
module aes_encrypt_controller #(
  parameter int         NR        = 10,
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic         rnd_final,
  input  logic [127:0] rnd_result,
  output logic [31:0]  ks_word,
  input  logic [31:0]  ks_sub,
  output logic [3:0]   round_idx
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ROUND = 2'b01,
    DONE  = 2'b10
  } fsm_t;

  fsm_t         fsm_r;
  fsm_t         fsm_s;
  logic [127:0] state_r;
  logic [127:0] key_r;
  logic [7:0]   rcon_r;
  logic [3:0]   round_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic [31:0]  n0_s;
  logic [31:0]  n1_s;
  logic [31:0]  n2_s;
  logic [31:0]  n3_s;
  logic         last_s;

  assign last_s = (round_r == LAST_ROUND);

  // Next round key from the current one and the substituted, rotated last word
  always_comb begin
    n0_s = key_r[127:96] ^ ks_sub ^ {rcon_r, 24'h000000};
    n1_s = key_r[95:64] ^ n0_s;
    n2_s = key_r[63:32] ^ n1_s;
    n3_s = key_r[31:0] ^ n2_s;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_r <= IDLE;
    else     fsm_r <= fsm_s;
  end

  // FSM next-state logic
  always_comb begin
    fsm_s = fsm_r;
    case (fsm_r)
      IDLE:    if (in_valid)  fsm_s = ROUND; else fsm_s = IDLE;
      ROUND:   if (last_s)    fsm_s = DONE;  else fsm_s = ROUND;
      DONE:    if (out_ready) fsm_s = IDLE;  else fsm_s = DONE;
      default: fsm_s = IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they are glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (fsm_s == IDLE);
      out_valid_r <= (fsm_s == DONE);
    end
  end

  // Cipher state, round key, Rcon and round counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= 128'h0;
      key_r   <= 128'h0;
      rcon_r  <= RCON_INIT;
      round_r <= 4'd0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (in_valid) begin
            state_r <= plaintext ^ key;
            key_r   <= key;
            rcon_r  <= RCON_INIT;
            round_r <= 4'd1;
          end
        end
        ROUND: begin
          state_r <= rnd_result;
          key_r   <= {n0_s, n1_s, n2_s, n3_s};
          rcon_r  <= xtime(rcon_r);
          if (!last_s) round_r <= round_r + 4'd1;
        end
        DONE: begin
          if (out_ready) round_r <= 4'd0;
        end
        default: round_r <= 4'd0;
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign ciphertext = state_r;
  assign rnd_state  = state_r;
  assign rnd_key    = {n0_s, n1_s, n2_s, n3_s};
  assign rnd_final  = (fsm_r == ROUND) && last_s;
  assign ks_word    = {key_r[23:0], key_r[31:24]};
  assign round_idx  = round_r;

endmodule

// File: tb/tb_aes_encrypt_controller.sv
// Self-checking bench: supplies the external round datapath and S-box, and checks
// the controller against FIPS-197 vectors and a high-level AES-128 reference model.
module tb_aes_encrypt_controller;

  localparam int NR = 10;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic         rnd_final;
  logic [127:0] rnd_result;
  logic [31:0]  ks_word;
  logic [31:0]  ks_sub;
  logic [3:0]   round_idx;

  int n_checks = 0;
  int n_errors = 0;

  aes_encrypt_controller #(.NR(NR), .RCON_INIT(8'h01)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .rnd_state(rnd_state), .rnd_key(rnd_key),
    .rnd_final(rnd_final), .rnd_result(rnd_result), .ks_word(ks_word),
    .ks_sub(ks_sub), .round_idx(round_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] base = x;
    for (int e = 0; e < 8; e++) begin
      if (e != 0) inv = gf_mul(inv, base);
      base = gf_mul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0] t [16];
    logic [7:0] u [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) t[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) u[r+4*c] = t[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
        u[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
        u[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
        u[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
        u[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = u[i];
    return o ^ k;
  endfunction

  // Reference: full key schedule into a word array, then NR rounds
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   rc = 8'h01;
    logic [127:0] s;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    s = pt ^ k;
    for (int r = 1; r <= NR; r++)
      s = aes_round(s, {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, r == NR);
    return s;
  endfunction

  // External combinational round datapath and S-box
  always_comb begin
    rnd_result = aes_round(rnd_state, rnd_key, rnd_final);
    ks_sub = sub_word(ks_word);
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_accept(input logic [127:0] pt, input logic [127:0] k);
    int n = 0;
    @(negedge clk);
    plaintext = pt; key = k; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check_value("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; plaintext = rand128(); key = rand128();
  endtask

  // Follows the ROUND cycles; optionally pokes a request in while busy
  task automatic wait_done(input int intrude, output logic [127:0] rk_last);
    int j = 0;
    int lat = -1;
    rk_last = '0;
    while (j < 40) begin
      @(negedge clk);
      if (out_valid) begin lat = j; in_valid = 1'b0; break; end
      check_value("round_idx", round_idx, j + 1);
      check_value("rnd_final", rnd_final, (j + 1 == NR));
      if (j + 1 == NR) rk_last = rnd_key;
      if (j + 1 == intrude) begin in_valid = 1'b1; plaintext = C_PT; key = C_KEY; end
      else in_valid = 1'b0;
      j++;
    end
    check_value("latency", lat, NR);
  endtask

  task automatic take_output(input logic [127:0] exp_ct, input int hold);
    check_value("ct", ciphertext, exp_ct);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_value("hold_valid", out_valid, 1'b1);
      check_value("hold_ct", ciphertext, exp_ct);
      check_value("hold_busy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_value("idle_ready", in_ready, 1'b1);
    check_value("idle_valid", out_valid, 1'b0);
    check_value("idle_round", round_idx, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rk;
    logic [127:0] pt;
    logic [127:0] k;
    logic [127:0] exp_q [$];
    int n = 0;
    int cyc = 0;
    int last_acc = -1;
    int n_acc = 0;
    int n_done = 0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    plaintext = '0; key = '0;
    @(negedge clk);
    check_value("rst_in_ready", in_ready, 1'b1);
    check_value("rst_out_valid", out_valid, 1'b0);
    check_value("rst_ct", ciphertext, 128'h0);
    check_value("rst_final", rnd_final, 1'b0);
    check_value("rst_round", round_idx, 4'd0);
    @(negedge clk); rst = 1'b0;

    // App.B with a busy-time request at round 5 and long back-pressure
    do_accept(B_PT, B_KEY);
    wait_done(5, rk);
    check_value("rk10", rk, B_RK10);
    take_output(B_CT, 20);

    do_accept(C_PT, C_KEY);
    wait_done(0, rk);
    take_output(C_CT, 1);

    // Abort in round 4, then a clean App.C.1 run
    do_accept(B_PT, B_KEY);
    n = 0;
    do begin @(negedge clk); n++; end while (round_idx != 4'd4 && n < 40);
    check_value("reach_round4", round_idx, 4'd4);
    rst = 1'b1; #1;
    check_value("abort_valid", out_valid, 1'b0);
    check_value("abort_round", round_idx, 4'd0);
    check_value("abort_ready", in_ready, 1'b1);
    @(negedge clk); rst = 1'b0;
    do_accept(C_PT, C_KEY);
    wait_done(0, rk);
    take_output(C_CT, 0);

    for (int b = 0; b < 3; b++) begin
      pt = rand128(); k = rand128();
      do_accept(pt, k);
      wait_done(0, rk);
      take_output(aes_ref(pt, k), $urandom_range(3, 0));
    end

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    while (n_done < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        check_value("b2b_final_done", rnd_final, 1'b0);
        if (exp_q.size() > 0) check_value("b2b_ct", ciphertext, exp_q.pop_front());
        else check_value("b2b_extra", out_valid, 1'b0);
        n_done++;
      end else if (!in_ready) begin
        check_value("b2b_final", rnd_final, (round_idx == 4'(NR)));
      end
      if (in_ready) begin
        if (n_acc < 8) begin
          if (last_acc >= 0) check_value("b2b_gap", cyc - last_acc, NR + 2);
          last_acc = cyc;
          pt = rand128(); k = rand128();
          plaintext = pt; key = k; in_valid = 1'b1;
          exp_q.push_back(aes_ref(pt, k));
          n_acc++;
        end else in_valid = 1'b0;
      end
    end
    check_value("b2b_count", n_done, 8);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
